avalon_pio_out_pulse: RTL



---
 rtl/avalon_pio_pkg.sv | 21 ++
 rtl/pio_pulse_timer.sv | 90 +++++++++
 rtl/avalon_pio_out_pulse.sv | 103 ++++++++++
 3 files changed

// File: rtl/avalon_pio_pkg.sv
// Shared register map, STATUS bit positions and pulse FSM state type for the
// pulsed Avalon-MM output port.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLR       = 3'd2;
    localparam logic [2:0] ADDR_PULSE     = 3'd3;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    localparam int unsigned BUSY   = 0;
    localparam int unsigned DONE   = 1;
    localparam int unsigned IRQ_EN = 2;

    typedef enum logic {
        StIdle,
        StActive
    } pulse_state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// One-shot pulse engine: holds the active mask high for a loaded number of
// clocks, supports retrigger/abort, and flags completion in a sticky done bit.
module pio_pulse_timer
    import avalon_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  pulse_we_i,
    input  logic [DATA_WIDTH-1:0] pulse_mask_i,
    input  logic [CNT_W-1:0]      pulse_len_i,
    input  logic                  done_clr_i,
    output logic [DATA_WIDTH-1:0] active_mask_o,
    output logic                  busy_o,
    output logic                  done_o
);

    pulse_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  done_set;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        done_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pulse_we_i && (pulse_mask_i != '0) && (pulse_len_i != '0)) begin
                    mask_d  = pulse_mask_i;
                    cnt_d   = pulse_len_i;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (pulse_we_i) begin
                    if (pulse_mask_i != '0) begin
                        mask_d = mask_q | pulse_mask_i;
                        cnt_d  = pulse_len_i;
                    end else begin
                        mask_d  = '0;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                // A retrigger with a zero length loads 0; treat it like 1 so it never wraps.
                end else if (cnt_q <= CNT_W'(1)) begin
                    mask_d   = '0;
                    cnt_d    = '0;
                    done_set = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Completion beats a simultaneous software clear.
        if (done_set) begin
            done_d = 1'b1;
        end else if (done_clr_i) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            mask_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign active_mask_o = mask_q;
    assign busy_o        = (state_q == StActive);
    assign done_o        = done_q;

endmodule

// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM output port with DATA/SET/CLR registers, a hardware one-shot pulse
// engine and a level completion interrupt.
module avalon_pio_out_pulse
    import avalon_pio_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH        = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE       = '0,
    parameter int unsigned           CNT_W             = 16,
    parameter int unsigned           DEFAULT_PULSE_LEN = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic                  irq_en_q, irq_en_d;

    logic                  wr;
    logic                  pulse_we;
    logic                  done_clr;
    logic [DATA_WIDTH-1:0] wr_bits;
    logic [DATA_WIDTH-1:0] active_mask;
    logic                  busy;
    logic                  done;
    logic                  unused_writedata;

    assign wr       = chipselect & ~write_n;
    assign wr_bits  = writedata[DATA_WIDTH-1:0];
    assign pulse_we = wr && (address == ADDR_PULSE);
    assign done_clr = wr && (address == ADDR_STATUS) && writedata[DONE];

    assign unused_writedata = ^writedata;

    always_comb begin
        data_d   = data_q;
        len_d    = len_q;
        irq_en_d = irq_en_q;
        if (wr) begin
            case (address)
                ADDR_DATA:      data_d   = wr_bits;
                ADDR_SET:       data_d   = data_q | wr_bits;
                ADDR_CLR:       data_d   = data_q & ~wr_bits;
                ADDR_PULSE_LEN: len_d    = writedata[CNT_W-1:0];
                ADDR_STATUS:    irq_en_d = writedata[IRQ_EN];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= RESET_VALUE;
            len_q    <= CNT_W'(DEFAULT_PULSE_LEN);
            irq_en_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            len_q    <= len_d;
            irq_en_q <= irq_en_d;
        end
    end

    pio_pulse_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk_i         (clk),
        .reset_i       (reset),
        .pulse_we_i    (pulse_we),
        .pulse_mask_i  (wr_bits),
        .pulse_len_i   (len_q),
        .done_clr_i    (done_clr),
        .active_mask_o (active_mask),
        .busy_o        (busy),
        .done_o        (done)
    );

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLR: readdata[DATA_WIDTH-1:0] = data_q;
            ADDR_PULSE:                    readdata[DATA_WIDTH-1:0] = active_mask;
            ADDR_PULSE_LEN:                readdata[CNT_W-1:0]      = len_q;
            ADDR_STATUS: begin
                readdata[BUSY]   = busy;
                readdata[DONE]   = done;
                readdata[IRQ_EN] = irq_en_q;
            end
            default: ;
        endcase
    end

    assign out_port = data_q | active_mask;
    assign irq      = done & irq_en_q;

endmodule
